mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU's MEM-stage store path, in parallel with the data memory.
- Decodes store address/data/mask/write-enable from the core, queues bytes in a small FIFO and serializes them 8N1 on a single `tx` line.
- Provides a status register readable through the load-data path, so firmware can poll and the simulation harness can capture console output.

---
 rtl/mmio_uart_tx.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter that sits on the MEM-stage store path.
//   Stores to TXDATA queue bytes in a small FIFO, and a TX FSM serializes
//   them onto `tx`. With UART_PARITY_EN undefined, frames are 8N1
//   (10*CLKS_PER_BIT cycles). STATUS can be polled through `rdata`.
//
//   Register window (16 bytes at BASE_ADDR, index = addr[3:2]):
//     0 TXDATA  write: push wdata[7:0] when wmask[0] is set; reads 0
//     1 STATUS  read : {bit8 parity, bit7:4 count (sat 15), bit3 overflow,
//                       bit2 busy, bit1 empty, bit0 full}
//               write: wmask[0] & wdata[3] clears overflow
//     2,3       read 0, writes ignored
//
//   Optional feature macro: UART_PARITY_EN
//     Inserts an even-parity bit between the data bits and the stop bit,
//     making frames 11*CLKS_PER_BIT cycles long. STATUS bit8 then reads 1.
//
//   Ports:
//     clk    system clock, rising edge
//     rst    asynchronous active-high reset
//     addr   byte address from the MEM stage
//     wdata  store data
//     wmask  byte-lane write mask
//     we     store enable
//     sel    combinational: addr lies inside the register window
//     rdata  combinational register read data
//     tx     registered serial output, idle high
//     busy   frame in flight or FIFO non-empty
`timescale 1ns/1ps

module mmio_uart_tx #(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned            FIFO_DEPTH   = 8,
    parameter int unsigned            CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wmask,
    input  logic                  we,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  tx,
    output logic                  busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // ---------------- address decode ----------------
    logic [1:0] reg_idx;
    logic       push_req;
    logic       ovf_clr;
    logic       unused_bits;

    assign sel      = (addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign reg_idx  = addr[3:2];
    assign push_req = we & sel & (reg_idx == 2'd0) & wmask[0];
    assign ovf_clr  = we & sel & (reg_idx == 2'd1) & wmask[0] & wdata[3];
    assign unused_bits = ^{addr[1:0], wdata[DATA_WIDTH-1:8], wmask[3:1]};

    // ---------------- FIFO ----------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q;
    logic             full, empty, push, pop;
    logic [7:0]       fifo_head;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign fifo_head = mem_q[rd_ptr_q];
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    assign push      = push_req & (~full | pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (ovf_clr)
                ovf_q <= 1'b0;
            else if (push_req & full & ~pop)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    // ---------------- TX FSM ----------------
    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    par_d   = ^fifo_head;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        par_d   = ^fifo_head;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // output logic: tx is registered, so it is computed from the next state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) | ~empty;

    // ---------------- register read ----------------
    logic [31:0] count_ext;
    logic [3:0]  count_sat;

    assign count_ext = 32'(count_q);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        rdata = '0;
        if (sel && (reg_idx == 2'd1)) begin
            rdata[0]   = full;
            rdata[1]   = empty;
            rdata[2]   = busy;
            rdata[3]   = ovf_q;
            rdata[7:4] = count_sat;
`ifdef UART_PARITY_EN
            rdata[8]   = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps

module tb_mmio_uart_tx;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CPB   = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
`ifdef UART_PARITY_EN
    localparam int unsigned NB   = 11;
    localparam logic [31:0] PBIT = 32'h100;
`else
    localparam int unsigned NB   = 10;
    localparam logic [31:0] PBIT = 32'h0;
`endif
    localparam logic [31:0] ST_EMPTY = 32'h2 | PBIT;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
    logic          we;
    logic          sel;
    logic [DW-1:0] rdata;
    logic          tx;
    logic          busy;

    mmio_uart_tx #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .wdata(wdata),
        .wmask(wmask),
        .we   (we),
        .sel  (sel),
        .rdata(rdata),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == int'(NB) - 1) return 1'b1;
        return ^d;
    endfunction

    // Line monitor: decodes frames at mid-bit and checks them against the scoreboard.
    logic       prev_tx = 1'b1;
    bit         mon_act = 1'b0;
    int         mon_cyc = 0;
    int         mon_k;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cyc = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cyc++;
        end
        if (mon_act && !rst && (mon_cyc % CPB) == CPB / 2) begin
            mon_k = mon_cyc / CPB;
            if (mon_k == 0) begin
                chk("mon_start_bit", {31'd0, tx}, 32'd0);
            end else if (mon_k <= 8) begin
                mon_byte[mon_k-1] = tx;
            end else if (mon_k < int'(NB) - 1) begin
                chk("mon_parity_bit", {31'd0, tx}, {31'd0, ^mon_byte});
            end else begin
                chk("mon_stop_bit", {31'd0, tx}, 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_extra_frame: got byte %02h want none", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("mon_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
                end
                mon_act = 1'b0;
            end
        end
        prev_tx = tx;
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wmask = 4'b0;
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        wr(BASE, {24'd0, b}, 4'b0001);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || mon_act) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        w;
        logic        esel;
        logic [31:0] erd;
    } vec_t;

    vec_t vt[13];

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{BASE + 32'h4,  32'h0,  4'b0000, 1'b0, 1'b1, ST_EMPTY};
        vt[1]  = '{BASE + 32'h0,  32'h0,  4'b0000, 1'b0, 1'b1, 32'h0};
        vt[2]  = '{BASE + 32'h8,  32'h0,  4'b0000, 1'b0, 1'b1, 32'h0};
        vt[3]  = '{BASE + 32'hC,  32'h0,  4'b0000, 1'b0, 1'b1, 32'h0};
        vt[4]  = '{BASE + 32'h7,  32'h0,  4'b0000, 1'b0, 1'b1, ST_EMPTY};
        vt[5]  = '{BASE + 32'h20, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{BASE + 32'h24, 32'h0,  4'b0000, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{BASE + 32'h20, 32'h55, 4'b0001, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{BASE + 32'h0,  32'h55, 4'b0010, 1'b1, 1'b1, 32'h0};
        vt[9]  = '{BASE + 32'h8,  32'h55, 4'b1111, 1'b1, 1'b1, 32'h0};
        vt[10] = '{BASE + 32'h4,  32'h8,  4'b0001, 1'b1, 1'b1, ST_EMPTY};
        vt[11] = '{BASE - 32'h4,  32'h0,  4'b0000, 1'b0, 1'b0, 32'h0};
        vt[12] = '{BASE + 32'h4,  32'h0,  4'b0000, 1'b0, 1'b1, ST_EMPTY};

        rst = 1'b1; addr = '0; wdata = '0; wmask = '0; we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        addr = BASE + 32'h4;
        #1;
        chk("reset_status", rdata, ST_EMPTY);
        chk("reset_tx",     {31'd0, tx},   32'd1);
        chk("reset_busy",   {31'd0, busy}, 32'd0);

        // decode / ignored-write vectors
        for (int i = 0; i < 13; i++) begin
            addr = vt[i].a; wdata = vt[i].d; wmask = vt[i].m; we = vt[i].w;
            #1;
            chk($sformatf("vec%0d_sel", i),   {31'd0, sel}, {31'd0, vt[i].esel});
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].erd);
            @(posedge clk);
            #1;
            we = 1'b0; wmask = 4'b0;
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            chk($sformatf("vec%0d_tx", i),   {31'd0, tx},   32'd1);
        end

        // single frame, cycle-exact waveform
        send(8'h55);
        chk("frame_tx_before_pop", {31'd0, tx}, 32'd1);
        for (int j = 0; j < int'(NB * CPB); j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("frame_tx_c%0d", j), {31'd0, tx}, {31'd0, fbit(8'h55, j / int'(CPB))});
        end
        chk("frame_busy_last", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("frame_busy_drop", {31'd0, busy}, 32'd0);
        chk("frame_tx_idle",   {31'd0, tx},   32'd1);

        // back-to-back frames
        repeat (3) @(posedge clk);
        #1;
        start_q.delete();
        send(8'h41);
        send(8'h42);
        send(8'h43);
        addr = BASE + 32'h4;
        #1;
        chk("b2b_status", rdata, 32'h24 | PBIT);
        wait_idle(3 * NB * CPB + 40);
        chk("b2b_frames", start_q.size(), 32'd3);
        if (start_q.size() == 3) begin
            chk("b2b_gap1", start_q[1] - start_q[0], NB * CPB);
            chk("b2b_gap2", start_q[2] - start_q[1], NB * CPB);
        end

        // overflow: 10 pushes in 10 cycles, one pop in between -> 9 kept
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'h30 + 8'(i));
            wr(BASE, 32'h30 + i, 4'b0001);
        end
        addr = BASE + 32'h4;
        #1;
        chk("ovf_status", rdata, 32'h8D | PBIT);
        wr(BASE + 32'h4, 32'h8, 4'b0001);
        addr = BASE + 32'h4;
        #1;
        chk("ovf_cleared", rdata, 32'h85 | PBIT);
        wait_idle(9 * NB * CPB + 60);

        // asynchronous reset during a data bit (0xC3: bit2 = 0)
        send(8'hC3);
        repeat (1 + 3 * CPB) @(posedge clk);
        #2;
        chk("rst_tx_before", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_tx_async",   {31'd0, tx},   32'd1);
        chk("rst_busy_async", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        addr = BASE + 32'h4;
        #1;
        chk("rst_status_after", rdata, ST_EMPTY);
        send(8'hA5);
        wait_idle(NB * CPB + 40);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
